adc_sampler: RTL and testbench
==============================

ADC_SAMPLER -- requirements
Module: adc_sampler

Interface
REQ-001 Parameter CLK_DIV, default 128: osc_clk cycles per adc_clk period; even, >= 4.
REQ-002 Parameter FRAME_BITS, default 16: adc_clk periods with adc_conv low per frame; range 4..32.
REQ-003 Parameter DATA_W, default 8: width of the published sample.
REQ-004 Parameter DATA_MSB, default 13: frame bit index (MSB first = FRAME_BITS-1) mapped to sample_data[DATA_W-1]; DATA_MSB-DATA_W+1 >= 0.
REQ-005 Parameter OVF_W, default 8: overrun counter width.
REQ-006 osc_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  level; start new frames while high.
REQ-009 decim  in  4  publish one frame in every decim+1.
REQ-010 adc_data  in  1  serial ADC output, MSB first.
REQ-011 trig_level  in  DATA_W  trigger threshold, unsigned.
REQ-012 sample_ready  in  1  consumer accepts sample.
REQ-013 adc_clk  out  1  divided ADC clock, 50% duty.
REQ-014 adc_conv  out  1  ADC conversion strobe.
REQ-015 sample_data  out  DATA_W  captured sample.
REQ-016 sample_valid  out  1  sample_data holds an unaccepted sample.
REQ-017 overrun  out  1  one-cycle pulse: completed sample dropped.
REQ-018 overrun_count  out  OVF_W  dropped-sample count, saturating.
REQ-019 trig_hit  out  1  one-cycle pulse on rising threshold crossing.

Function
REQ-020 Divider counts 0..CLK_DIV-1 and wraps; adc_clk registered, low for counts 0..CLK_DIV/2-1, high otherwise; rise_tick = cycle count becomes CLK_DIV/2.
REQ-021 Divider and adc_clk run whenever not in reset, regardless of enable.
REQ-022 FSM states IDLE, CONV, SHIFT; all transitions occur only on rise_tick.
REQ-023 IDLE: adc_conv=0; on rise_tick with enable=1 -> CONV, adc_conv=1.
REQ-024 CONV: lasts exactly one adc_clk period; next rise_tick -> SHIFT, adc_conv=0, bit counter=0.
REQ-025 SHIFT: each rise_tick shifts adc_data into a FRAME_BITS shift register; on the FRAME_BITS-th capture, frame completes -> CONV if enable=1, else IDLE.
REQ-026 enable deasserted mid-frame: current frame completes normally; no new frame starts.
REQ-027 Frame completion: sample = frame bits DATA_MSB..DATA_MSB-DATA_W+1; decimation counter increments, and the frame is published when the counter equals decim, after which the counter clears; decim=0 publishes every frame.
REQ-028 decim changed mid-run: new value applies at the next completion; counter > new decim publishes immediately and clears.
REQ-029 Publish: sample_valid=0, or sample_valid=1 with sample_ready=1 that cycle -> sample_data/sample_valid=1 updated on the next osc_clk edge (latency one cycle after final capture).
REQ-030 Publish with sample_valid=1 and sample_ready=0: new sample discarded, sample_data held, overrun pulses one cycle, overrun_count increments, saturating at 2^OVF_W-1.
REQ-031 sample_valid clears on the cycle after sample_valid&sample_ready unless REQ-029 reloads it; sample_data stable while sample_valid=1 and sample_ready=0.

Reset
REQ-032 reset=1: FSM IDLE, divider 0, adc_clk 0, adc_conv 0, sample_data 0, sample_valid 0, overrun 0, overrun_count 0, trig_hit 0, decimation counter 0, trigger history cleared.
REQ-033 Reset mid-frame discards the partial frame; first frame after release starts at the first rise_tick with enable=1.

Configuration
REQ-034 Macro ADC_SAMPLER_TRIGGER_EN defined: on each published sample, trig_hit pulses with sample_valid rise when previous published sample < trig_level and new sample >= trig_level; first sample after reset never triggers; dropped samples do not update history.
REQ-035 Macro undefined: trig_hit constant 0, trig_level ignored, no trigger logic synthesised.

Verification
REQ-036 CLK_DIV=4, FRAME_BITS=16, enable=1, adc_data drives 16'h3FC0, sample_ready=1 -> sample_data=8'hFF one cycle after the 16th capture; adc_conv high exactly 4 osc_clk cycles per 68-cycle frame.
REQ-037 decim=2, ramp frames 0x01,0x02,0x03,... -> published 0x03, 0x06, 0x09.
REQ-038 sample_ready=0 for 3 frames -> first sample held, overrun pulses twice, overrun_count=2; OVF_W=2 with 5 drops -> count saturates at 3.
REQ-039 reset=1 asserted at frame bit 7 for one cycle -> all outputs 0 next cycle, no sample published for that frame.
REQ-040 enable dropped at frame bit 3 -> frame completes, sample published, FSM IDLE, adc_conv stays 0.
REQ-041 ADC_SAMPLER_TRIGGER_EN, trig_level=8'h80, samples 0x10,0x7F,0x80,0x90,0x20,0xFF -> trig_hit pulses on 0x80 and 0xFF only; macro undefined -> trig_hit never asserts.

Source files
------------

// File: rtl/adc_sampler_if.sv
// rtl/adc_sampler_if.sv - sample stream interface between adc_sampler and its consumer
//
// Signals:
//   sample_data   captured sample (DATA_W bits), driven by the sampler
//   sample_valid  sample_data holds an unaccepted sample, driven by the sampler
//   sample_ready  consumer accepts the sample this cycle, driven by the consumer
interface adc_sampler_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/adc_sampler.sv
// rtl/adc_sampler.sv - serial ADC frame sampler with decimation, overrun tracking and optional trigger
//
// Optional feature macro: ADC_SAMPLER_TRIGGER_EN (rising threshold-crossing detector on trig_hit)
//
// Ports:
//   osc_clk        in   sole clock, rising edge
//   reset          in   synchronous active-high reset
//   enable         in   start new frames while high
//   decim          in   publish one frame in every decim+1
//   adc_data       in   serial ADC data, MSB first
//   trig_level     in   unsigned trigger threshold
//   adc_clk        out  divided ADC clock, 50% duty
//   adc_conv       out  conversion strobe, high for one adc_clk period per frame
//   overrun        out  one-cycle pulse when a completed sample is dropped
//   overrun_count  out  saturating count of dropped samples
//   trig_hit       out  one-cycle pulse on rising threshold crossing
//   smp            sample stream, master side (sample_data/sample_valid out, sample_ready in)
module adc_sampler #(
    parameter int CLK_DIV    = 128,
    parameter int FRAME_BITS = 16,
    parameter int DATA_W     = 8,
    parameter int DATA_MSB   = 13,
    parameter int OVF_W      = 8
) (
    input  logic               osc_clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [3:0]         decim,
    input  logic               adc_data,
    input  logic [DATA_W-1:0]  trig_level,
    output logic               adc_clk,
    output logic               adc_conv,
    output logic               overrun,
    output logic [OVF_W-1:0]   overrun_count,
    output logic               trig_hit,
    adc_sampler_if.master      smp
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(FRAME_BITS);
    // Frame bits above DATA_MSB never reach the sample, so the shift register stops there.
    localparam int SH_W  = DATA_MSB + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               adc_clk_q, adc_clk_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SH_W-1:0]    shreg_q, shreg_d;
    logic               done_q, done_d;
    logic               rise_tick;

    logic [3:0]         dec_cnt_q, dec_cnt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic [OVF_W-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic [DATA_W-1:0]  sample_w;
    logic               publish;
    logic               accept;

    // Divider: free-running whenever out of reset; rise_tick marks the edge where it reaches CLK_DIV/2.
    assign div_d     = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    assign rise_tick = (div_q == DIV_W'(CLK_DIV / 2 - 1));
    assign adc_clk_d = (div_d >= DIV_W'(CLK_DIV / 2));

    // State register
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            adc_clk_q <= 1'b0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            adc_clk_q <= adc_clk_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: every transition and capture happens on rise_tick.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        done_d    = 1'b0;
        if (rise_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d = S_CONV;
                    end
                end
                S_CONV: begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                end
                S_SHIFT: begin
                    shreg_d   = {shreg_q[SH_W-2:0], adc_data};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
                        done_d  = 1'b1;
                        state_d = enable ? S_CONV : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        adc_conv = (state_q == S_CONV);
    end

    // Publish path runs the cycle after the final capture, once shreg_q holds the whole frame.
    // Comparing with >= lets a lowered decim publish at once when the counter is already past it.
    assign sample_w = shreg_q[DATA_MSB -: DATA_W];
    assign publish  = done_q && (dec_cnt_q >= decim);
    assign accept   = publish && (!valid_q || smp.sample_ready);

    always_comb begin
        dec_cnt_d = dec_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovf_d     = 1'b0;
        ovf_cnt_d = ovf_cnt_q;
        if (done_q) begin
            dec_cnt_d = publish ? 4'd0 : dec_cnt_q + 4'd1;
        end
        if (accept) begin
            data_d  = sample_w;
            valid_d = 1'b1;
        end else if (publish) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != {OVF_W{1'b1}}) begin
                ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
            end
        end else if (valid_q && smp.sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            dec_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign adc_clk          = adc_clk_q;
    assign overrun          = ovf_q;
    assign overrun_count    = ovf_cnt_q;
    assign smp.sample_data  = data_q;
    assign smp.sample_valid = valid_q;

`ifdef ADC_SAMPLER_TRIGGER_EN
    // History only follows accepted samples; have_prev_q keeps the first sample after reset from firing.
    logic [DATA_W-1:0] prev_q;
    logic              have_prev_q;
    logic              trig_q;

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            trig_q <= accept && have_prev_q && (prev_q < trig_level) && (sample_w >= trig_level);
            if (accept) begin
                prev_q      <= sample_w;
                have_prev_q <= 1'b1;
            end
        end
    end

    assign trig_hit = trig_q;
`else
    logic unused_trig_level;
    assign unused_trig_level = ^trig_level;
    assign trig_hit          = 1'b0;
`endif
endmodule

// File: tb/tb_adc_sampler.sv
// tb/tb_adc_sampler.sv - self-checking bench for adc_sampler
`timescale 1ns/1ps
module tb_adc_sampler;
    localparam int CLK_DIV    = 4;
    localparam int FRAME_BITS = 16;
    localparam int DATA_W     = 8;
    localparam int DATA_MSB   = 13;
    localparam int OVF_W      = 2;
    localparam int LSB        = DATA_MSB - DATA_W + 1;
    localparam int OVF_MAX    = (1 << OVF_W) - 1;
`ifdef ADC_SAMPLER_TRIGGER_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    logic              osc_clk = 1'b1;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [3:0]        decim = 4'd0;
    logic              adc_data = 1'b0;
    logic [DATA_W-1:0] trig_level = '0;
    logic              adc_clk, adc_conv, overrun, trig_hit;
    logic [OVF_W-1:0]  overrun_count;

    adc_sampler_if #(.DATA_W(DATA_W)) smp ();

    adc_sampler #(
        .CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS), .DATA_W(DATA_W),
        .DATA_MSB(DATA_MSB), .OVF_W(OVF_W)
    ) dut (
        .osc_clk(osc_clk), .reset(reset), .enable(enable), .decim(decim),
        .adc_data(adc_data), .trig_level(trig_level), .adc_clk(adc_clk),
        .adc_conv(adc_conv), .overrun(overrun), .overrun_count(overrun_count),
        .trig_hit(trig_hit), .smp(smp)
    );

    always #5 osc_clk = ~osc_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge osc_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: 0 idle, 1 conversion period, 2 shifting. Stepped at the falling edge with the inputs
    // the DUT will sample on the next rising edge, so it predicts the outputs after that edge.
    int                m_div = 0, m_phase = 0, m_nbits = 0, m_dec = 0, m_fstart = 0;
    logic [31:0]       m_frame = '0;
    bit                m_pend = 0, m_have_prev = 0, m_live = 0;
    logic [DATA_W-1:0] m_pend_s = '0, m_prev = '0;
    logic [DATA_W-1:0] e_data = '0;
    bit                e_clk = 0, e_conv = 0, e_valid = 0, e_ovf = 0, e_trig = 0;
    int                e_ocnt = 0;

    task automatic model_step();
        bit rise, pub;
        if (reset) begin
            m_div = 0; m_phase = 0; m_nbits = 0; m_dec = 0; m_pend = 0; m_have_prev = 0;
            e_clk = 0; e_conv = 0; e_data = '0; e_valid = 0; e_ovf = 0; e_trig = 0; e_ocnt = 0;
            return;
        end
        m_div = (m_div + 1) % CLK_DIV;
        rise  = (m_div == CLK_DIV / 2);
        e_clk = (m_div >= CLK_DIV / 2);
        e_ovf = 0; e_trig = 0; pub = 0;
        if (m_pend) begin
            m_pend = 0;
            if (m_dec >= int'(decim)) begin m_dec = 0; pub = 1; end
            else m_dec++;
        end
        if (pub && (!e_valid || smp.sample_ready)) begin
            e_trig = TRIG_EN && m_have_prev && (m_prev < trig_level) && (m_pend_s >= trig_level);
            m_prev = m_pend_s; m_have_prev = 1;
            e_data = m_pend_s; e_valid = 1;
        end else if (pub) begin
            e_ovf = 1;
            if (e_ocnt < OVF_MAX) e_ocnt++;
        end else if (e_valid && smp.sample_ready) begin
            e_valid = 0;
        end
        if (rise) begin
            case (m_phase)
                0: if (enable) begin m_phase = 1; m_nbits = 0; m_fstart++; end
                1: begin m_phase = 2; m_nbits = 0; end
                default: begin
                    m_frame = (m_frame << 1) | 32'(adc_data);
                    m_nbits++;
                    if (m_nbits == FRAME_BITS) begin
                        m_pend   = 1;
                        m_pend_s = DATA_W'(m_frame >> LSB);
                        m_nbits  = 0;
                        m_phase  = enable ? 1 : 0;
                        if (enable) m_fstart++;
                    end
                end
            endcase
        end
        e_conv = (m_phase == 1);
    endtask

    // Single compare process: DUT outputs against the model every cycle.
    always @(negedge osc_clk) begin
        if (m_live) begin
            check("adc_clk", adc_clk, e_clk);
            check("adc_conv", adc_conv, e_conv);
            check("sample_data", smp.sample_data, e_data);
            check("sample_valid", smp.sample_valid, e_valid);
            check("overrun", overrun, e_ovf);
            check("overrun_count", overrun_count, e_ocnt);
            check("trig_hit", trig_hit, e_trig);
        end
        model_step();
        m_live = 1;
    end

    // ---------------- DUT observation for directed expectations ----------------
    logic [DATA_W-1:0] pubs[$];
    int                pub_cyc[$];
    int                conv_at[$];
    logic [DATA_W-1:0] trig_vals[$];
    int                ovf_pulses = 0, conv_hi = 0;
    logic              prev_valid = 1'b0, prev_ready = 1'b0;

    always @(negedge osc_clk) begin
        if (adc_conv === 1'b1) conv_hi++;
        if (smp.sample_valid === 1'b1 && (prev_valid !== 1'b1 || prev_ready === 1'b1)) begin
            pubs.push_back(smp.sample_data);
            pub_cyc.push_back(cyc);
            conv_at.push_back(conv_hi);
        end
        if (overrun === 1'b1) ovf_pulses++;
        if (trig_hit === 1'b1) trig_vals.push_back(smp.sample_data);
        prev_valid = smp.sample_valid;
        prev_ready = smp.sample_ready;
    end

    // ---------------- serial data source ----------------
    int                    mode = 0;  // 0 random, 1 constant, 2 ramp, 3 list
    logic [FRAME_BITS-1:0] const_word = '0;
    logic [DATA_W-1:0]     ramp_v = '0;
    logic [DATA_W-1:0]     list_q[$];
    logic [FRAME_BITS-1:0] cur_word = '0;
    int                    last_f = 0;

    function automatic logic [FRAME_BITS-1:0] next_word();
        logic [FRAME_BITS-1:0] w;
        w = FRAME_BITS'($urandom);
        case (mode)
            1: w = const_word;
            2: begin ramp_v++; w[DATA_MSB -: DATA_W] = ramp_v; end
            3: if (list_q.size() > 0) w[DATA_MSB -: DATA_W] = list_q.pop_front();
            default: ;
        endcase
        return w;
    endfunction

    always @(posedge osc_clk) begin
        #2;
        if (m_fstart != last_f) begin
            last_f   = m_fstart;
            cur_word = next_word();
        end
        if (m_phase != 0) adc_data = cur_word[FRAME_BITS-1-m_nbits];
        else              adc_data = 1'($urandom);
    end

    // ---------------- sequencing ----------------
    int rel_cyc = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge osc_clk);
        #1;
    endtask

    task automatic rst_on();
        reset = 1'b1;
        tick(1);
    endtask

    task automatic rst_off();
        tick(2);
        reset   = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic clear_obs();
        pubs.delete(); pub_cyc.delete(); conv_at.delete(); trig_vals.delete();
        ovf_pulses = 0;
    endtask

    task automatic wait_pubs(input int n, input int budget);
        for (int i = 0; i < budget && pubs.size() < n; i++) tick(1);
        check("wait_pubs", 32'(pubs.size() >= n), 1);
    endtask

    task automatic wait_ovf(input int n, input int budget);
        for (int i = 0; i < budget && ovf_pulses < n; i++) tick(1);
        check("wait_overrun", 32'(ovf_pulses >= n), 1);
    endtask

    task automatic wait_bit(input int nb, input int budget);
        for (int i = 0; i < budget && !(m_phase == 2 && m_nbits == nb); i++) tick(1);
        check("wait_frame_bit", 32'(m_phase == 2 && m_nbits == nb), 1);
    endtask

    initial begin
        logic [DATA_W-1:0] tlist [6];
        int                npub0, conv0, rdy_pct;
        tlist = '{8'h10, 8'h7F, 8'h80, 8'h90, 8'h20, 8'hFF};
        smp.sample_ready = 1'b1;

        // Reset state and the 16'h3FC0 frame
        rst_on();
        tick(1);
        check("rst_adc_clk", adc_clk, 0);
        check("rst_adc_conv", adc_conv, 0);
        check("rst_valid", smp.sample_valid, 0);
        check("rst_data", smp.sample_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_ovf_count", overrun_count, 0);
        check("rst_trig", trig_hit, 0);
        mode = 1; const_word = 16'h3FC0; decim = 4'd0; enable = 1'b1;
        clear_obs();
        rst_off();
        wait_pubs(2, 400);
        check("fixed_sample0", pubs[0], 8'hFF);
        check("fixed_sample1", pubs[1], 8'hFF);
        check("first_pub_latency", pub_cyc[0] - rel_cyc, 71);
        check("frame_period", pub_cyc[1] - pub_cyc[0], 68);
        check("conv_cycles_per_frame", conv_at[1] - conv_at[0], 4);

        // Decimation by 3 over a ramp
        rst_on();
        mode = 2; ramp_v = '0; decim = 4'd2;
        clear_obs();
        rst_off();
        wait_pubs(3, 800);
        check("decim_pub0", pubs[0], 8'h03);
        check("decim_pub1", pubs[1], 8'h06);
        check("decim_pub2", pubs[2], 8'h09);

        // Stalled consumer: hold, overrun pulses, saturating count
        rst_on();
        mode = 2; ramp_v = '0; decim = 4'd0; smp.sample_ready = 1'b0;
        clear_obs();
        rst_off();
        wait_ovf(2, 400);
        tick(2);
        check("stall_pub_count", pubs.size(), 1);
        check("stall_held_data", smp.sample_data, 8'h01);
        check("stall_ovf_pulses", ovf_pulses, 2);
        check("stall_ovf_count2", overrun_count, 2);
        wait_ovf(5, 400);
        tick(2);
        check("stall_ovf_pulses5", ovf_pulses, 5);
        check("stall_ovf_saturated", overrun_count, 3);
        check("stall_still_held", smp.sample_data, 8'h01);
        smp.sample_ready = 1'b1;
        tick(1);
        check("drain_valid_clear", smp.sample_valid, 0);

        // Reset pulse at frame bit 7 discards the frame
        rst_on();
        mode = 0; decim = 4'd0; enable = 1'b1;
        clear_obs();
        rst_off();
        wait_bit(7, 200);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_adc_clk", adc_clk, 0);
        check("midrst_adc_conv", adc_conv, 0);
        check("midrst_valid", smp.sample_valid, 0);
        check("midrst_data", smp.sample_data, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_ovf_count", overrun_count, 0);
        check("midrst_trig", trig_hit, 0);
        tick(60);
        check("midrst_no_publish", pubs.size(), 0);

        // Enable dropped at frame bit 3: the frame still completes, nothing new starts
        wait_bit(3, 200);
        enable = 1'b0;
        npub0 = pubs.size();
        conv0 = conv_hi;
        for (int i = 0; i < 200 && pubs.size() == npub0; i++) tick(1);
        check("endis_published", pubs.size(), npub0 + 1);
        tick(3 * 68);
        check("endis_conv_quiet", conv_hi - conv0, 0);
        check("endis_one_publish", pubs.size(), npub0 + 1);

        // Threshold crossing sequence
        rst_on();
        mode = 3; list_q.delete();
        foreach (tlist[i]) list_q.push_back(tlist[i]);
        decim = 4'd0; trig_level = 8'h80; smp.sample_ready = 1'b1; enable = 1'b1;
        clear_obs();
        rst_off();
        wait_pubs(6, 600);
        tick(2);
        foreach (tlist[i]) check($sformatf("trig_seq_pub%0d", i), pubs[i], tlist[i]);
`ifdef ADC_SAMPLER_TRIGGER_EN
        check("trig_count", trig_vals.size(), 2);
        if (trig_vals.size() == 2) begin
            check("trig_on_0x80", trig_vals[0], 8'h80);
            check("trig_on_0xFF", trig_vals[1], 8'hFF);
        end
`else
        check("trig_never", trig_vals.size(), 0);
`endif

        // Randomized run against the model
        rst_on();
        mode = 0; decim = 4'd0; enable = 1'b1;
        rst_off();
        rdy_pct = 100;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                rdy_pct    = $urandom_range(10, 100);
                trig_level = DATA_W'($urandom);
            end
            smp.sample_ready = ($urandom_range(1, 100) <= rdy_pct);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 299) == 0) decim = 4'($urandom_range(0, 3));
            reset = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
